// File: rtl/avalon_user_iochannel.sv
// avalon_user_iochannel: terminates the user-bus aw/w/b and ar/r channels into a write FIFO drained
// by the core and a read FIFO returned as bursts. IOCHANNEL_WADDR_EN adds per-beat wr_deq_addr.
module avalon_user_iochannel_fifo #(
  parameter int W  = 32,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         ready
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_p0;
  logic [AW-1:0] rptr_p0;
  logic [AW:0]   cnt_p0;
  logic          do_push;
  logic          do_pop;

  assign ready   = cnt_p0 < (AW+1)'(DEPTH);
  assign valid   = cnt_p0 != '0;
  assign do_push = push && ready;
  assign do_pop  = pop && valid;
  assign dout    = mem[rptr_p0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_p0 <= '0;
      rptr_p0 <= '0;
      cnt_p0  <= '0;
    end else begin
      if (do_push) wptr_p0 <= wptr_p0 + AW'(1);
      if (do_pop)  rptr_p0 <= rptr_p0 + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_p0 <= cnt_p0 + (AW+1)'(1);
        2'b01:   cnt_p0 <= cnt_p0 - (AW+1)'(1);
        default: cnt_p0 <= cnt_p0;
      endcase
    end
  end

  // Storage carries data only; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_p0] <= din;
  end
endmodule

module avalon_user_iochannel #(
  parameter int C_AVS_ADDR_WIDTH = 32,
  parameter int C_AVS_DATA_WIDTH = 32,
  parameter int FIFO_ADDR_WIDTH  = 4,
  parameter int BRESP_CNT_WIDTH  = 4
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic                        awvalid,
  input  logic [C_AVS_ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]                  awlen,
  output logic                        awready,
  input  logic [C_AVS_DATA_WIDTH-1:0] wdata,
  input  logic                        wlast,
  input  logic                        wvalid,
  output logic                        wready,
  output logic                        bvalid,
  input  logic                        bready,
  input  logic                        arvalid,
  input  logic [C_AVS_ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]                  arlen,
  output logic                        arready,
  output logic [C_AVS_DATA_WIDTH-1:0] rdata,
  output logic                        rlast,
  output logic                        rvalid,
  input  logic                        rready,
  output logic [C_AVS_DATA_WIDTH-1:0] wr_deq_data,
`ifdef IOCHANNEL_WADDR_EN
  output logic [C_AVS_ADDR_WIDTH-1:0] wr_deq_addr,
`endif
  output logic                        wr_deq_valid,
  input  logic                        wr_deq_ready,
  input  logic [C_AVS_DATA_WIDTH-1:0] rd_enq_data,
  input  logic                        rd_enq_valid,
  output logic                        rd_enq_ready
);
`ifdef IOCHANNEL_WADDR_EN
  localparam int WF_W = C_AVS_DATA_WIDTH + C_AVS_ADDR_WIDTH;
`else
  localparam int WF_W = C_AVS_DATA_WIDTH;
`endif

  typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;

  logic [7:0]                 beat_cnt_p0;
  logic [BRESP_CNT_WIDTH-1:0] bresp_cnt_p0;
  logic                       wf_ready;
  logic [WF_W-1:0]            wf_din;
  logic [WF_W-1:0]            wf_dout;
  logic                       w_acc;
  logic                       w_first;
  logic [7:0]                 w_len;
  logic                       w_done;
  logic                       b_dec;

  rd_state_t                  state_p0;
  rd_state_t                  state_nxt;
  logic [8:0]                 rem_p0;
  logic                       rf_valid;
  logic [C_AVS_DATA_WIDTH-1:0] rf_dout;
  logic                       rd_load;
  logic                       unused_sink;

  // Write path: address and data handshakes share one ready so upstream waitrequest stays coherent.
  assign wready  = wf_ready;
  assign awready = wf_ready;
  assign w_acc   = wvalid && wf_ready;
  assign w_first = beat_cnt_p0 == 8'd0;
  assign w_len   = awvalid ? awlen : 8'd0;
  assign w_done  = w_acc && (w_first ? (w_len == 8'd0) : (beat_cnt_p0 == 8'd1));
  assign bvalid  = bresp_cnt_p0 != '0;
  assign b_dec   = bvalid && bready;

`ifdef IOCHANNEL_WADDR_EN
  logic [C_AVS_ADDR_WIDTH-1:0] waddr_nxt_p0;
  logic [C_AVS_ADDR_WIDTH-1:0] w_addr;

  assign w_addr      = w_first ? awaddr : waddr_nxt_p0;
  assign wf_din      = {w_addr, wdata};
  assign wr_deq_addr = wf_dout[WF_W-1 -: C_AVS_ADDR_WIDTH];

  always_ff @(posedge ACLK) begin
    if (w_acc) waddr_nxt_p0 <= w_addr + C_AVS_ADDR_WIDTH'(C_AVS_DATA_WIDTH / 8);
  end
`else
  assign wf_din = wdata;
`endif
  assign wr_deq_data = wf_dout[C_AVS_DATA_WIDTH-1:0];

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      beat_cnt_p0  <= 8'd0;
      bresp_cnt_p0 <= '0;
    end else begin
      if (w_acc) beat_cnt_p0 <= w_first ? w_len : beat_cnt_p0 - 8'd1;
      case ({w_done, b_dec})
        2'b10:   if (bresp_cnt_p0 != '1) bresp_cnt_p0 <= bresp_cnt_p0 + BRESP_CNT_WIDTH'(1);
        2'b01:   bresp_cnt_p0 <= bresp_cnt_p0 - BRESP_CNT_WIDTH'(1);
        default: bresp_cnt_p0 <= bresp_cnt_p0;
      endcase
    end
  end

  avalon_user_iochannel_fifo #(.W(WF_W), .AW(FIFO_ADDR_WIDTH)) u_wr_fifo (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .push  (wvalid),
    .din   (wf_din),
    .pop   (wr_deq_ready),
    .dout  (wf_dout),
    .valid (wr_deq_valid),
    .ready (wf_ready)
  );

  // Read path: FIFO head feeds a single output register, refilled whenever it empties or is taken.
  avalon_user_iochannel_fifo #(.W(C_AVS_DATA_WIDTH), .AW(FIFO_ADDR_WIDTH)) u_rd_fifo (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .push  (rd_enq_valid),
    .din   (rd_enq_data),
    .pop   (rd_load),
    .dout  (rf_dout),
    .valid (rf_valid),
    .ready (rd_enq_ready)
  );

  assign arready = state_p0 == RD_IDLE;
  assign rd_load = (state_p0 == RD_BURST) && (!rvalid || rready) && rf_valid && (rem_p0 != 9'd0);

  always_ff @(posedge ACLK) begin
    if (!ARESETN) state_p0 <= RD_IDLE;
    else          state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      RD_IDLE:  if (arvalid) state_nxt = RD_BURST;
      RD_BURST: if (rvalid && rready && rlast) state_nxt = RD_IDLE;
      default:  state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rem_p0 <= 9'd0;
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      rdata  <= '0;
    end else begin
      if (state_p0 == RD_IDLE && arvalid) rem_p0 <= {1'b0, arlen} + 9'd1;
      if (rd_load) begin
        rdata  <= rf_dout;
        rvalid <= 1'b1;
        rlast  <= rem_p0 == 9'd1;
        rem_p0 <= rem_p0 - 9'd1;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
        rlast  <= 1'b0;
      end
    end
  end

  assign unused_sink = ^{wlast, araddr
`ifndef IOCHANNEL_WADDR_EN
                         , awaddr
`endif
                         };
endmodule
